// File: rtl/viterbi_link_ctrl.sv
// viterbi_link_ctrl: frame sequencer for the encoder -> channel -> Viterbi link.
//
// Feeds FRAME_LEN payload bits and TAIL_LEN zero flush bits to the encoder,
// windows channel error injection to the first ERR_WIN encoder cycles, and
// compares decoder output against a DEC_LAT-deep delayed copy of the payload.
//
// Optional build macro: VLC_PRBS_EN
//   defined   : payload comes from an internal PRBS-15 (x^15+x^14+1, seed 7FFF)
//   undefined : payload comes from src_bit_i
//
// Frame latency: a start accepted at rising edge T0 makes done_o high in the
// clock period that begins at edge T0+FRAME_LEN+DEC_LAT+2 (TAIL_LEN <= DEC_LAT+1;
// for longer tails, edge T0+FRAME_LEN+TAIL_LEN+1).
module viterbi_link_ctrl #(
    parameter int FRAME_LEN = 256,
    parameter int TAIL_LEN  = 8,
    parameter int DEC_LAT   = 16,
    parameter int ERR_WIN   = 256,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             src_bit_i,
    output logic             src_rdy_o,
    output logic             enc_en_o,
    output logic             enc_bit_o,
    output logic             inj_en_o,
    input  logic             dec_bit_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic [CNT_W-1:0] bit_cnt_o
);

    localparam int          TOTAL     = FRAME_LEN + TAIL_LEN;
    localparam int          IDX_W     = $clog2(TOTAL + 1);
    localparam logic [31:0] ERR_WIN_U = 32'(ERR_WIN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_FLUSH,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [IDX_W-1:0]   r_idx;
    logic               r_enc_en;
    logic               r_enc_bit;
    logic               r_inj;
    logic               r_pflag;
    logic [DEC_LAT-1:0] r_pipe_bit;
    logic [DEC_LAT-1:0] r_pipe_flag;
    logic [CNT_W-1:0]   r_err_cnt;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic               w_accept;
    logic               w_payload_bit;

    assign w_accept = (r_state == S_IDLE) && start_i;

`ifdef VLC_PRBS_EN
    logic [14:0] r_lfsr;
    logic        w_unused_src;

    assign w_unused_src  = src_bit_i;
    assign w_payload_bit = r_lfsr[14];

    // PRBS-15 payload source, reseeded per frame, advanced once per consumed bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr <= 15'h7FFF;
        end else if (w_accept) begin
            r_lfsr <= 15'h7FFF;
        end else if (r_state == S_SEND) begin
            r_lfsr <= {r_lfsr[13:0], r_lfsr[14] ^ r_lfsr[13]};
        end
    end
`else
    assign w_payload_bit = src_bit_i;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; DRAIN waits until no payload bit is in flight
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_next = S_SEND;
                end
            end
            S_SEND: begin
                if (r_idx == IDX_W'(FRAME_LEN - 1)) begin
                    w_next = (TAIL_LEN == 0) ? S_DRAIN : S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (r_idx == IDX_W'(TOTAL - 1)) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!r_pflag && !(|r_pipe_flag)) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Encoder-side registers and encoder cycle index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx     <= '0;
            r_enc_en  <= 1'b0;
            r_enc_bit <= 1'b0;
            r_inj     <= 1'b0;
            r_pflag   <= 1'b0;
        end else begin
            r_enc_en  <= 1'b0;
            r_enc_bit <= 1'b0;
            r_inj     <= 1'b0;
            r_pflag   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_idx <= '0;
                    end
                end
                S_SEND: begin
                    r_enc_en  <= 1'b1;
                    r_enc_bit <= w_payload_bit;
                    r_pflag   <= 1'b1;
                    r_inj     <= (32'(r_idx) < ERR_WIN_U);
                    r_idx     <= r_idx + 1'b1;
                end
                S_FLUSH: begin
                    r_enc_en  <= 1'b1;
                    r_inj     <= (32'(r_idx) < ERR_WIN_U);
                    r_idx     <= r_idx + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Compare pipeline: {sent bit, payload flag} delayed to meet dec_bit_i
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pipe_bit  <= '0;
            r_pipe_flag <= '0;
        end else if (w_accept) begin
            r_pipe_bit  <= '0;
            r_pipe_flag <= '0;
        end else begin
            for (int unsigned i = DEC_LAT - 1; i > 0; i--) begin
                r_pipe_bit[i]  <= r_pipe_bit[i-1];
                r_pipe_flag[i] <= r_pipe_flag[i-1];
            end
            r_pipe_bit[0]  <= r_enc_bit;
            r_pipe_flag[0] <= r_pflag;
        end
    end

    // Saturating compared-bit and mismatch counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_cnt <= '0;
            r_bit_cnt <= '0;
        end else if (w_accept) begin
            r_err_cnt <= '0;
            r_bit_cnt <= '0;
        end else if (r_pipe_flag[DEC_LAT-1]) begin
            if (r_bit_cnt != '1) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
            if ((r_pipe_bit[DEC_LAT-1] != dec_bit_i) && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
        end
    end

    assign src_rdy_o = (r_state == S_SEND);
    assign busy_o    = (r_state != S_IDLE);
    assign done_o    = (r_state == S_DONE);
    assign enc_en_o  = r_enc_en;
    assign enc_bit_o = r_enc_bit;
    assign inj_en_o  = r_inj;
    assign err_cnt_o = r_err_cnt;
    assign bit_cnt_o = r_bit_cnt;

endmodule

// File: tb/tb_viterbi_link_ctrl.sv
// Directed bench for viterbi_link_ctrl. Main instance: FRAME_LEN=8, TAIL_LEN=2,
// DEC_LAT=4, ERR_WIN=5. Second instance: FRAME_LEN=20, CNT_W=4 for saturation.
// Decoder stubs replay enc_bit_o four cycles later, with selectable inversion.
module tb_viterbi_link_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    // main instance
    logic        start, src_bit, src_rdy, enc_en, enc_bit, inj_en, dec_bit, busy, done;
    logic [15:0] err_cnt, bit_cnt;
    // saturation instance
    logic        start_s, src_bit_s, src_rdy_s, enc_en_s, enc_bit_s, inj_s, dec_s, busy_s, done_s;
    logic [3:0]  err_s, bit_s;

    viterbi_link_ctrl #(.FRAME_LEN(8), .TAIL_LEN(2), .DEC_LAT(4), .ERR_WIN(5), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start_i(start), .src_bit_i(src_bit), .src_rdy_o(src_rdy),
        .enc_en_o(enc_en), .enc_bit_o(enc_bit), .inj_en_o(inj_en), .dec_bit_i(dec_bit),
        .busy_o(busy), .done_o(done), .err_cnt_o(err_cnt), .bit_cnt_o(bit_cnt)
    );

    viterbi_link_ctrl #(.FRAME_LEN(20), .TAIL_LEN(2), .DEC_LAT(4), .ERR_WIN(256), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .start_i(start_s), .src_bit_i(src_bit_s), .src_rdy_o(src_rdy_s),
        .enc_en_o(enc_en_s), .enc_bit_o(enc_bit_s), .inj_en_o(inj_s), .dec_bit_i(dec_s),
        .busy_o(busy_s), .done_o(done_s), .err_cnt_o(err_s), .bit_cnt_o(bit_s)
    );

    // Decoder stub for the main instance: delay 4, invert encoder indices set in inv_mask
    logic [3:0]  q_bit = '0;
    int          q_tag [0:3] = '{-1, -1, -1, -1};
    int          enc_count = 0;
    logic [31:0] inv_mask = '0;
    logic        stub_inv;

    always @(posedge clk) begin
        enc_count <= enc_en ? enc_count + 1 : 0;
        q_bit     <= {q_bit[2:0], enc_bit};
        q_tag[0]  <= enc_en ? enc_count : -1;
        q_tag[1]  <= q_tag[0];
        q_tag[2]  <= q_tag[1];
        q_tag[3]  <= q_tag[2];
    end

    always_comb begin
        stub_inv = 1'b0;
        if (q_tag[3] >= 0 && q_tag[3] < 32) stub_inv = inv_mask[q_tag[3]];
    end
    assign dec_bit = q_bit[3] ^ stub_inv;

    // Decoder stub for the saturation instance: delay 4, invert everything
    logic [3:0] qs = '0;
    always @(posedge clk) qs <= {qs[2:0], enc_bit_s};
    assign dec_s = ~qs[3];

    int   checks = 0;
    int   errors = 0;
    logic en_log  [0:63];
    logic bit_log [0:63];
    logic inj_log [0:63];
    int   done_n;
    int   first_bc;
    int   first_ec;
    int   lat_ref = 14;

    // Start request accepted at the next rising edge (DUT assumed idle)
    task automatic start_frame();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Runs one frame from the period after acceptance until done_o is seen
    task automatic frame_body(input logic [7:0] bits, input bit extra);
        int kk = 0;
        done_n = -1;
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            en_log[n]  = enc_en;
            bit_log[n] = enc_bit;
            inj_log[n] = inj_en;
            if (n == 0) begin
                first_bc = int'(bit_cnt);
                first_ec = int'(err_cnt);
            end
            if (src_rdy && kk < 8) begin
                src_bit = bits[kk];
                kk++;
            end
            if (extra) start = (n == 3 || n == 9 || n == 11);
            if (done) begin
                done_n = n;
                break;
            end
        end
        if (extra) start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; src_bit = 1'b0; start_s = 1'b0; src_bit_s = 1'b1;
        #12;
        checks++;
        if ({busy, enc_en, inj_en, done, src_rdy, err_cnt, bit_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_main got %b expected all zero",
                     {busy, enc_en, inj_en, done, src_rdy, err_cnt, bit_cnt});
        end
        checks++;
        if ({busy_s, enc_en_s, inj_s, done_s, src_rdy_s, err_s, bit_s} !== '0) begin
            errors++;
            $display("FAIL reset_sat got %b expected all zero",
                     {busy_s, enc_en_s, inj_s, done_s, src_rdy_s, err_s, bit_s});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [7:0] pat = 8'h4D;
        logic       exp_b;
        inv_mask = '0;
        start_frame();
        frame_body(pat, 1'b0);
        checks++;
        if (done_n < 14 || done_n > 16) begin
            errors++;
            $display("FAIL latency_window got %0d expected 14..16", done_n);
        end
        if (done_n >= 0) lat_ref = done_n;
        for (int n = 0; n < 14; n++) begin
            checks++;
            if (en_log[n] !== (n >= 1 && n <= 10)) begin
                errors++;
                $display("FAIL enc_en period %0d got %b expected %b", n, en_log[n], (n >= 1 && n <= 10));
            end
        end
`ifndef VLC_PRBS_EN
        for (int n = 1; n <= 10; n++) begin
            exp_b = (n <= 8) ? pat[n-1] : 1'b0;
            checks++;
            if (bit_log[n] !== exp_b) begin
                errors++;
                $display("FAIL enc_bit period %0d got %b expected %b", n, bit_log[n], exp_b);
            end
        end
`endif
        checks++;
        if (err_cnt !== 16'd0 || bit_cnt !== 16'd8) begin
            errors++;
            $display("FAIL basic_counts got err %0d bits %0d expected err 0 bits 8", err_cnt, bit_cnt);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_single got done %b busy %b expected 0 0", done, busy);
        end
    endtask

    task automatic test_inject();
        inv_mask = '0;
        start_frame();
        frame_body(8'hA5, 1'b0);
        for (int n = 0; n < 14; n++) begin
            checks++;
            if (inj_log[n] !== (n >= 1 && n <= 5)) begin
                errors++;
                $display("FAIL inj_en period %0d got %b expected %b", n, inj_log[n], (n >= 1 && n <= 5));
            end
        end
        checks++;
        if (done_n !== lat_ref) begin
            errors++;
            $display("FAIL latency_inject got %0d expected %0d", done_n, lat_ref);
        end
        @(negedge clk);
    endtask

    task automatic test_errors();
        inv_mask = 32'h0000_0044;
        start_frame();
        frame_body(8'h4D, 1'b0);
        checks++;
        if (err_cnt !== 16'd2 || bit_cnt !== 16'd8) begin
            errors++;
            $display("FAIL payload_errors got err %0d bits %0d expected err 2 bits 8", err_cnt, bit_cnt);
        end
        @(negedge clk);
        inv_mask = 32'h0000_0244;
        start_frame();
        frame_body(8'h4D, 1'b0);
        checks++;
        if (err_cnt !== 16'd2 || bit_cnt !== 16'd8) begin
            errors++;
            $display("FAIL tail_error got err %0d bits %0d expected err 2 bits 8", err_cnt, bit_cnt);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        inv_mask = 32'h0000_0001;
        start_frame();
        frame_body(8'hB2, 1'b1);
        checks++;
        if (done_n !== lat_ref) begin
            errors++;
            $display("FAIL ignored_start_latency got %0d expected %0d", done_n, lat_ref);
        end
        checks++;
        if (err_cnt !== 16'd1 || bit_cnt !== 16'd8) begin
            errors++;
            $display("FAIL b2b_first_counts got err %0d bits %0d expected err 1 bits 8", err_cnt, bit_cnt);
        end
        start = 1'b1;  // held through the DONE cycle
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || bit_cnt !== 16'd8) begin
            errors++;
            $display("FAIL done_ignores_start got busy %b done %b bits %0d expected 0 0 8", busy, done, bit_cnt);
        end
        @(posedge clk);
        #1 start = 1'b0;
        inv_mask = 32'h0000_0044;
        frame_body(8'h4D, 1'b0);
        checks++;
        if (first_bc !== 0 || first_ec !== 0) begin
            errors++;
            $display("FAIL restart_clear got err %0d bits %0d expected 0 0", first_ec, first_bc);
        end
        checks++;
        if (err_cnt !== 16'd2 || bit_cnt !== 16'd8 || done_n !== lat_ref) begin
            errors++;
            $display("FAIL b2b_second got err %0d bits %0d lat %0d expected 2 8 %0d",
                     err_cnt, bit_cnt, done_n, lat_ref);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int saw_done = 0;
        // counters held at 1/8 from previous frame: async clear in IDLE
        inv_mask = 32'h0000_0008;
        start_frame();
        frame_body(8'h4D, 1'b0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (err_cnt !== 16'd0 || bit_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_idle_counts got err %0d bits %0d expected 0 0", err_cnt, bit_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        start_frame();
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            src_bit = 1'b1;
        end
        checks++;
        if (enc_en !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_active got enc_en %b busy %b expected 1 1", enc_en, busy);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, enc_en, inj_en, src_rdy, done, err_cnt, bit_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_mid_send got %b expected all zero",
                     {busy, enc_en, inj_en, src_rdy, done, err_cnt, bit_cnt});
        end
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (done || busy) saw_done++;
        end
        checks++;
        if (saw_done !== 0) begin
            errors++;
            $display("FAIL no_done_after_reset got %0d active cycles expected 0", saw_done);
        end
        inv_mask = 32'h0000_0010;
        start_frame();
        frame_body(8'h3C, 1'b0);
        checks++;
        if (err_cnt !== 16'd1 || bit_cnt !== 16'd8 || done_n !== lat_ref) begin
            errors++;
            $display("FAIL after_reset_frame got err %0d bits %0d lat %0d expected 1 8 %0d",
                     err_cnt, bit_cnt, done_n, lat_ref);
        end
        @(negedge clk);
    endtask

    task automatic test_saturation();
        int         seen = 0;
        logic [14:0] lfsr = 15'h7FFF;
        logic        exp_b;
        int          bad = 0;
        @(negedge clk);
        start_s = 1'b1;
        @(posedge clk);
        #1 start_s = 1'b0;
        for (int n = 0; n < 80; n++) begin
            @(negedge clk);
            if (n >= 1 && n <= 15) begin
                exp_b = lfsr[14];
                lfsr  = {lfsr[13:0], lfsr[14] ^ lfsr[13]};
                if (enc_bit_s !== exp_b) bad++;
            end
            if (done_s) begin
                seen = 1;
                break;
            end
        end
        checks++;
        if (seen == 0) begin
            errors++;
            $display("FAIL sat_timeout got no done_o expected done within 80 cycles");
        end
        checks++;
        if (err_s !== 4'hF || bit_s !== 4'hF) begin
            errors++;
            $display("FAIL saturation got err %h bits %h expected F F", err_s, bit_s);
        end
`ifdef VLC_PRBS_EN
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL prbs_first15 got %0d wrong bits expected 0", bad);
        end
`endif
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_inject();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
